// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Also services MTHI/MTLO. Optional macro: MULDIV_FAST_MULT_EN (1-cycle multiply).
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, op       request strobe and opcode (000 MULT .. 101 MTLO, 11x no-op)
//   A, B            rs / rt operands
//   busy, done      in-flight flag, 1-cycle completion pulse
//   div_zero        pulses with done when a divide had B==0
//   Hi, Lo          architectural HI/LO registers
module hilo_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] a_raw;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              dz;

  logic              can_accept;
  logic              op_mul;
  logic              op_div;
  logic              op_mthi;
  logic              op_mtlo;
  logic              sgn;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   quo_s;
  logic [DATA_W-1:0]   rem_s;

  // A new request may land in the DONE cycle as well as in IDLE.
  assign can_accept = start && (state == IDLE || state == DONE);

  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    unique case (1'b1)
      (op[2:1] == 2'b00): op_mul  = 1'b1;
      (op[2:1] == 2'b01): op_div  = 1'b1;
      (op == 3'b100):     op_mthi = 1'b1;
      (op == 3'b101):     op_mtlo = 1'b1;
      default:            ;
    endcase
  end

  // Even opcodes in the mul/div group are the signed variants.
  assign sgn   = ~op[0] & ~op[2];
  assign a_neg = sgn & A[DATA_W-1];
  assign b_neg = sgn & B[DATA_W-1];
  assign a_mag = a_neg ? ('0 - A) : A;
  assign b_mag = b_neg ? ('0 - B) : B;

  // Shift-add step: acc_lo holds the multiplier, low product bits
  // shift in from the top as multiplier bits are consumed.
  assign mul_sum = {1'b0, acc_hi}
                 + {1'b0, (acc_lo[0] ? opnd : '0)};

  // Restoring step: acc_hi is the partial remainder, acc_lo
  // shifts dividend bits out and quotient bits in.
  assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg_q ? ('0 - prod) : prod;
  assign quo_s  = neg_q ? ('0 - acc_lo) : acc_lo;
  assign rem_s  = neg_r ? ('0 - acc_hi) : acc_hi;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*DATA_W-1:0] fast_mag;
  logic [2*DATA_W-1:0] fast_prod;

  assign fast_mag  = {{DATA_W{1'b0}}, a_mag}
                   * {{DATA_W{1'b0}}, b_mag};
  assign fast_prod = (a_neg ^ b_neg) ? ('0 - fast_mag)
                                     : fast_mag;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (can_accept) begin
            if (op_mthi) Hi <= A;
            if (op_mtlo) Lo <= A;
            if (op_div) begin
              state  <= CALC;
              busy   <= 1'b1;
              cnt    <= '0;
              is_div <= 1'b1;
              acc_hi <= '0;
              acc_lo <= a_mag;
              opnd   <= b_mag;
              a_raw  <= A;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              dz     <= (B == '0);
            end
            if (op_mul) begin
`ifdef MULDIV_FAST_MULT_EN
              state <= DONE;
              done  <= 1'b1;
              Hi    <= fast_prod[2*DATA_W-1:DATA_W];
              Lo    <= fast_prod[DATA_W-1:0];
`else
              state  <= CALC;
              busy   <= 1'b1;
              cnt    <= '0;
              is_div <= 1'b0;
              acc_hi <= '0;
              acc_lo <= b_mag;
              opnd   <= a_mag;
              a_raw  <= A;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= 1'b0;
              dz     <= 1'b0;
`endif
            end
          end
        end
        CALC: begin
          if (is_div) begin
            if (!div_diff[DATA_W]) begin
              acc_hi <= div_diff[DATA_W-1:0];
            end else begin
              acc_hi <= div_shift[DATA_W-1:0];
            end
            acc_lo <= {acc_lo[DATA_W-2:0],
                       ~div_diff[DATA_W]};
          end else begin
            acc_hi <= mul_sum[DATA_W:1];
            acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
          end
          if (cnt == LAST) begin
            state <= FIXUP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIXUP: begin
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= is_div & dz;
          if (!is_div) begin
            Hi <= prod_s[2*DATA_W-1:DATA_W];
            Lo <= prod_s[DATA_W-1:0];
          end else if (dz) begin
            // Divide by zero still takes full latency.
            Hi <= a_raw;
            Lo <= '1;
          end else begin
            Hi <= rem_s;
            Lo <= quo_s;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors and sequences
// for hilo_muldiv_unit at DATA_W=32.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int total;
  int bad;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_DC = 1;
  localparam int MUL_NB = 0;
`else
  localparam int MUL_DC = 34;
  localparam int MUL_NB = 33;
`endif

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  // Issue one op, scramble A/B after accept, watch 60 cycles.
  task automatic run_op(input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int dcyc,
                        output int nbusy,
                        output int ndone,
                        output logic [31:0] hi,
                        output logic [31:0] lo,
                        output logic dz);
    @(negedge clk);
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    dcyc = -1;
    nbusy = 0;
    ndone = 0;
    hi = '0;
    lo = '0;
    dz = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = c;
          hi = Hi;
          lo = Lo;
          dz = div_zero;
        end
      end
    end
  endtask

  initial begin
    int dc;
    int nb;
    int nd;
    logic [31:0] h;
    logic [31:0] l;
    logic z;
    bit ismul;

    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    op = 3'b111;
    A = '0;
    B = '0;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MULT, 32'hFFFFFFFD, 32'd7,
                 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{DIV, 32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{DIVU, 32'd7, 32'd2,
                 32'd1, 32'd3, 1'b0};
    vecs[4]  = '{DIV, 32'h80000000, 32'hFFFFFFFF,
                 32'd0, 32'h80000000, 1'b0};
    vecs[5]  = '{DIVU, 32'd5, 32'd0,
                 32'd5, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{DIV, 32'd7, 32'hFFFFFFFE,
                 32'd1, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{MULT, 32'h80000000, 32'h80000000,
                 32'h40000000, 32'd0, 1'b0};
    vecs[8]  = '{MULTU, 32'h00010000, 32'h00010000,
                 32'd1, 32'd0, 1'b0};
    vecs[9]  = '{DIV, 32'hFFFFFFF8, 32'd0,
                 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{DIVU, 32'd100, 32'd7,
                 32'd2, 32'd14, 1'b0};
    vecs[11] = '{MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'd0, 32'd1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b,
             dc, nb, nd, h, l, z);
      ismul = (vecs[i].op[2:1] == 2'b00);
      chk($sformatf("v%0d_hi", i), 64'(h), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(l), 64'(vecs[i].lo));
      chk($sformatf("v%0d_dz", i), 64'(z), 64'(vecs[i].dz));
      chk($sformatf("v%0d_dcyc", i), 64'(dc),
          64'(ismul ? MUL_DC : 34));
      chk($sformatf("v%0d_nbusy", i), 64'(nb),
          64'(ismul ? MUL_NB : 33));
      chk($sformatf("v%0d_ndone", i), 64'(nd), 64'd1);
    end

    // Starts while busy are dropped, including MTHI.
    @(negedge clk);
    start = 1'b1;
    op = DIVU;
    A = 32'd6;
    B = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    h = '0;
    l = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        h = Hi;
        l = Lo;
      end
      start = 1'b0;
      if (c == 10) begin
        start = 1'b1;
        op = DIV;
        A = 32'd9;
        B = 32'd3;
      end else if (c == 15) begin
        start = 1'b1;
        op = MTHI;
        A = 32'h1234;
      end
    end
    chk("ign_ndone", 64'(nd), 64'd1);
    chk("ign_hi", 64'(h), 64'd2);
    chk("ign_lo", 64'(l), 64'd1);
    chk("ign_mthi", 64'(Hi), 64'd2);

    @(negedge clk);
    start = 1'b1;
    op = MTHI;
    A = 32'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("mthi_hi", 64'(Hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    start = 1'b1;
    op = MTLO;
    A = 32'hBEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("mtlo_lo", 64'(Lo), 64'hBEEF);
    chk("mtlo_hi", 64'(Hi), 64'h1234);
    chk("mtlo_done", 64'(done), 64'd0);

    // Reset in cycle 15 of a DIV aborts it.
    @(negedge clk);
    start = 1'b1;
    op = DIV;
    A = 32'd100;
    B = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(Hi), 64'd0);
    chk("abort_lo", 64'(Lo), 64'd0);
    nd = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_ndone", 64'(nd), 64'd0);

    run_op(DIVU, 32'd9, 32'd3, dc, nb, nd, h, l, z);
    chk("post_lo", 64'(l), 64'd3);
    chk("post_hi", 64'(h), 64'd0);
    chk("post_dcyc", 64'(dc), 64'd34);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    op = MTHI;
    A = 32'h5555;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_hi", 64'(Hi), 64'd0);

    // Back-to-back: second op accepted in the DONE cycle.
    @(negedge clk);
    start = 1'b1;
    op = DIVU;
    A = 32'd7;
    B = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 60 && dc < 0; c++) begin
      @(negedge clk);
      if (done) dc = c;
    end
    chk("b2b_first", 64'(dc), 64'd34);
    start = 1'b1;
    op = DIVU;
    A = 32'd100;
    B = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    dc = -1;
    h = '0;
    l = '0;
    for (int c = 1; c <= 60 && dc < 0; c++) begin
      @(negedge clk);
      if (done) begin
        dc = c;
        h = Hi;
        l = Lo;
      end
    end
    chk("b2b_dcyc", 64'(dc), 64'd34);
    chk("b2b_lo", 64'(l), 64'd14);
    chk("b2b_hi", 64'(h), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
